// File: rtl/dbus_responder.sv
// Data-bus responder: doubleword RAM behind the CPU request/response handshake, one transaction in flight.
// Define DBUS_RESPONDER_RANDOM_STALL_EN to add 0-7 pseudo-random extra wait cycles per transaction.

package dbus_responder_pkg;
   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      logic [2:0]  size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;
endpackage

module dbus_responder
   import dbus_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 12,
   parameter int LATENCY    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  dbus_req_t  dreq,
   output dbus_resp_t dresp,
   output logic       busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

`ifdef DBUS_RESPONDER_RANDOM_STALL_EN
   localparam int EXTRA = 7;
`else
   localparam int EXTRA = 0;
`endif
   localparam int CNT_W = $clog2(LATENCY + EXTRA + 2);

   logic [1:0]            state;
   logic [CNT_W-1:0]      counter;
   logic [CNT_W-1:0]      load_val;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [7:0]            strobe_q;
   logic [63:0]           wdata_q;
   logic [63:0]           mem [0:(1<<DEPTH_LOG2)-1];
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  unused_req;

   // Upper address bits alias; low three bits and size carry no meaning here.
   assign req_idx    = dreq.addr[DEPTH_LOG2+2:3];
   assign unused_req = ^{dreq.size, dreq.addr[63:DEPTH_LOG2+3], dreq.addr[2:0]};

`ifdef DBUS_RESPONDER_RANDOM_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   assign load_val = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);
`else
   assign load_val = CNT_W'(LATENCY);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         counter  <= '0;
         idx_q    <= '0;
         strobe_q <= '0;
         wdata_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (dreq.valid) begin
                  idx_q    <= req_idx;
                  strobe_q <= dreq.strobe;
                  wdata_q  <= dreq.data;
                  counter  <= load_val;
                  state    <= (load_val != '0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               counter <= counter - CNT_W'(1);
               if (counter == CNT_W'(1)) begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // The write lands on the edge that ends RESP, so a following read already sees it.
   always_ff @(posedge clk) begin
      if (state == S_RESP) begin
         for (int k = 0; k < 8; k++) begin
            if (strobe_q[k]) begin
               mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
         end
      end
   end

   always_comb begin
      dresp = '0;
      busy  = (state != S_IDLE);
      if (state == S_RESP) begin
         dresp.addr_ok = 1'b1;
         dresp.data_ok = 1'b1;
         if (strobe_q == 8'h00) begin
            dresp.data = mem[idx_q];
         end
      end
   end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: one instance at LATENCY=2, one at LATENCY=0.
// Exact response cycles are checked in the default build, a 0-7 cycle window with DBUS_RESPONDER_RANDOM_STALL_EN.

module tb_dbus_responder;
   import dbus_responder_pkg::*;

   logic       clk;
   logic       rst;
   dbus_req_t  dreq;
   dbus_req_t  dreq0;
   dbus_resp_t dresp;
   dbus_resp_t dresp0;
   logic       busy;
   logic       busy0;

   int total_cnt;
   int bad_cnt;

   dbus_responder #(.DEPTH_LOG2(12), .LATENCY(2)) dut (
      .clk   (clk),
      .rst   (rst),
      .dreq  (dreq),
      .dresp (dresp),
      .busy  (busy)
   );

   dbus_responder #(.DEPTH_LOG2(12), .LATENCY(0)) dut0 (
      .clk   (clk),
      .rst   (rst),
      .dreq  (dreq0),
      .dresp (dresp0),
      .busy  (busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issues one request from cycle 0, drops valid and scrambles the bus right after accept.
   task automatic run_txn(input bit sel, input logic [63:0] a, input logic [7:0] s,
                          input logic [63:0] d, output logic [63:0] rd, output int lat,
                          output logic busy_mid, output logic [1:0] post);
      dbus_req_t  r;
      dbus_resp_t rs;
      r        = '0;
      r.valid  = 1'b1;
      r.addr   = a;
      r.size   = 3'd3;
      r.strobe = s;
      r.data   = d;
      rd       = '0;
      lat      = -1;
      busy_mid = 1'b0;
      post     = 2'b11;
      @(posedge clk); #1;
      if (sel) dreq0 = r; else dreq = r;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         rs = sel ? dresp0 : dresp;
         if (c == 1) busy_mid = sel ? busy0 : busy;
         if (rs.data_ok) begin
            lat = c;
            rd  = rs.data;
            break;
         end
         @(posedge clk); #1;
         if (c == 0) begin
            r.valid  = 1'b0;
            r.addr   = ~a;
            r.strobe = ~s;
            r.data   = ~d;
            if (sel) dreq0 = r; else dreq = r;
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      rs   = sel ? dresp0 : dresp;
      post = {rs.data_ok, sel ? busy0 : busy};
   endtask

   task automatic applyStimulus(input string tag, input bit sel, input logic [63:0] a,
                                input logic [7:0] s, input logic [63:0] d, input logic [63:0] exp_data);
      logic [63:0] rd;
      int          lat;
      int          lo;
      logic        busy_mid;
      logic [1:0]  post;
      run_txn(sel, a, s, d, rd, lat, busy_mid, post);
      lo = sel ? 1 : 3;
`ifdef DBUS_RESPONDER_RANDOM_STALL_EN
      checkOutput({tag, "_lat_window"}, 64'((lat >= lo && lat <= lo + 7) ? 1 : 0), 64'd1);
`else
      checkOutput({tag, "_lat"}, 64'(lat), 64'(lo));
`endif
      checkOutput({tag, "_data"}, rd, exp_data);
      checkOutput({tag, "_post"}, {62'b0, post}, 64'd0);
      if (!sel) checkOutput({tag, "_busy_wait"}, {63'b0, busy_mid}, 64'd1);
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      rst       = 1'b0;
      dreq      = '0;
      dreq0     = '0;

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("rst_ctl", {61'b0, busy, dresp.addr_ok, dresp.data_ok}, 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("idle_ctl", {61'b0, busy, dresp.addr_ok, dresp.data_ok}, 64'd0);
         checkOutput("idle_data", dresp.data, 64'd0);
      end

      $display("[TB] write/read, partial strobe");
      applyStimulus("wr_full", 1'b0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 64'd0);
      applyStimulus("rd_full", 1'b0, 64'h8000_0010, 8'h00, 64'd0, 64'h1122_3344_5566_7788);
      applyStimulus("wr_part", 1'b0, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_DEAD_BEEF, 64'd0);
      applyStimulus("rd_part", 1'b0, 64'h8000_0010, 8'h00, 64'd0, 64'h1122_3344_DEAD_BEEF);

      $display("[TB] aliasing");
      applyStimulus("wr_idx1", 1'b0, 64'h8, 8'hFF, 64'h0000_0000_0000_CAFE, 64'd0);
      applyStimulus("wr_idx0", 1'b0, 64'h0, 8'hFF, 64'h5, 64'd0);
      applyStimulus("rd_alias", 1'b0, 64'h8000, 8'h00, 64'd0, 64'h5);
      applyStimulus("rd_idx1", 1'b0, 64'h8, 8'h00, 64'd0, 64'h0000_0000_0000_CAFE);

      $display("[TB] reset during WAIT");
      @(posedge clk); #1;
      dreq        = '0;
      dreq.valid  = 1'b1;
      dreq.addr   = 64'h8000_0010;
      dreq.strobe = 8'hFF;
      dreq.data   = 64'h9999_9999_9999_9999;
      @(posedge clk); #1;
      dreq.valid = 1'b0;
      rst        = 1'b0;
      #1;
      checkOutput("abort_ctl", {61'b0, busy, dresp.addr_ok, dresp.data_ok}, 64'd0);
      checkOutput("abort_data", dresp.data, 64'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      applyStimulus("rd_abort", 1'b0, 64'h8000_0010, 8'h00, 64'd0, 64'h1122_3344_DEAD_BEEF);

      $display("[TB] zero latency");
      applyStimulus("z_wr0", 1'b1, 64'h0, 8'hFF, 64'h0000_0000_0000_A0A0, 64'd0);
      applyStimulus("z_wr1", 1'b1, 64'h8, 8'hFF, 64'h0000_0000_0000_B1B1, 64'd0);
`ifdef DBUS_RESPONDER_RANDOM_STALL_EN
      applyStimulus("z_rd0", 1'b1, 64'h0, 8'h00, 64'd0, 64'h0000_0000_0000_A0A0);
      applyStimulus("z_rd1", 1'b1, 64'h8, 8'h00, 64'd0, 64'h0000_0000_0000_B1B1);
`else
      begin
         logic [5:0]  ok_seq;
         logic [63:0] d1;
         logic [63:0] d3;
         ok_seq = '0;
         d1     = '0;
         d3     = '0;
         @(posedge clk); #1;
         dreq0        = '0;
         dreq0.valid  = 1'b1;
         dreq0.addr   = 64'h0;
         for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ok_seq[c] = dresp0.data_ok;
            if (c == 1) d1 = dresp0.data;
            if (c == 3) d3 = dresp0.data;
            @(posedge clk); #1;
            if (c == 1) dreq0.addr = 64'h8;
            if (c == 3) dreq0.valid = 1'b0;
         end
         checkOutput("z_held_okseq", {58'b0, ok_seq}, 64'b001010);
         checkOutput("z_held_d1", d1, 64'h0000_0000_0000_A0A0);
         checkOutput("z_held_d3", d3, 64'h0000_0000_0000_B1B1);
      end
`endif

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Data-bus slave: the responder end of the CPU's data-bus request/response protocol. It drives the response struct consumed by the CPU's memory stage.
- Backed by a doubleword-organised RAM with configurable response latency and one outstanding transaction.
- Instantiated in the simulation top beside the CPU. Replaces the external data memory model for pipeline stall and handshake testing.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 64-bit doublewords (default 4096 x 8 B = 32 KiB)
- LATENCY, 2, wait cycles between accept and response (0 allowed)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- dreq  input  dbus_req_t  request struct with these fields:
  - valid: 1 bit
  - addr: 64 bits, byte address
  - size: 3 bits, msize
  - strobe: 8 bits, byte write enables; 0 means read
  - data: 64 bits, write data, byte lanes aligned to addr[2:0]
- dresp  output  dbus_resp_t  response struct with these fields:
  - addr_ok: 1 bit
  - data_ok: 1 bit
  - data: 64 bits
- busy  output  1  high while a transaction is accepted but not yet responded

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0, dresp all zeros, busy=0.
  - RAM contents are not cleared.
  - Reset mid-transaction abandons it silently; a pending write is not committed.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If dreq.valid=1, latch addr/strobe/data into internal registers, set busy=1, and load counter=LATENCY.
  - Next state is WAIT if LATENCY>0, else RESP.
  - dresp is 0 in IDLE.
- WAIT:
  - Counter decrements each cycle; when counter==1, the next state is RESP.
  - dreq is ignored. Changes to dreq.valid/addr/data during WAIT do not alter the latched transaction.
  - Deasserting valid does not cancel the transaction.
- RESP (exactly one cycle):
  - dresp.addr_ok=1 and dresp.data_ok=1.
  - Read (latched strobe==0): dresp.data = RAM[idx], the full aligned doubleword; the CPU extracts bytes by addr[2:0]/size.
  - Write: dresp.data=0; byte k of RAM[idx] is written with latched data byte k when strobe[k]=1, at the rising edge ending RESP.
  - Next state is IDLE and busy falls with it.
- Index and addressing rules:
  - idx = addr[DEPTH_LOG2+2:3]. Upper address bits are ignored, so addresses alias and wrap modulo RAM size.
  - addr[2:0] is not checked; alignment is the initiator's responsibility.
- Latency: with valid first high in cycle 0, data_ok is high in cycle LATENCY+1.
- Back-to-back: the cycle after RESP is IDLE and a held valid is accepted there. Minimum issue interval is LATENCY+2 cycles.
- Read-after-write to the same idx returns the new value, because the write commits before the next accept.
- size is informational only; strobe alone controls writes.
- All outputs are registered or decoded from state only; there is no combinational path from dreq to dresp.

Optional Feature:
- Macro: DBUS_RESPONDER_RANDOM_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) advances every cycle.
  - On accept, counter is loaded with LATENCY + lfsr[2:0], giving 0-7 extra wait cycles.
  - WAIT is always entered when the loaded value is >0.
- When undefined: fixed LATENCY, no LFSR logic is generated.

Test Plan:
- Reset then idle, LATENCY=2: hold rst=0 for 3 cycles, release, dreq.valid=0 for 10 cycles -> dresp.addr_ok/data_ok/data stay 0 and busy=0 throughout.
- Write then read, LATENCY=2:
  - Write addr=0x80000010, strobe=0xFF, data=0x1122334455667788, valid from cycle 0 -> data_ok=1 only in cycle 3.
  - Read of the same addr -> data_ok in its cycle 3 with data=0x1122334455667788.
- Partial strobe: over the value above, write strobe=0x0F, data=0xAAAAAAAA_DEADBEEF, then read -> 0x11223344DEADBEEF.
- Aliasing, DEPTH_LOG2=12: write 0x5 to addr 0x0, read addr 0x8000 -> 0x5; read addr 0x8 -> unaffected value.
- Valid drop and reset abort:
  - Accept a write, drop valid during WAIT -> the write still commits and data_ok still pulses.
  - Separately, assert rst=0 during WAIT of a write -> dresp=0 immediately; a later read returns the old data.
- LATENCY=0 with valid held high continuously for two reads -> data_ok in cycles 1 and 3. With DBUS_RESPONDER_RANDOM_STALL_EN, data_ok comes 1 to 8 cycles after accept and data matches.
